// File: rtl/alu_ctrl_pkg.sv
// Shared command codes, function-code width and FSM state encoding
// for the ALU command controller.
package alu_ctrl_pkg;

    localparam logic [7:0]  CMD_ALU_OPER   = 8'hCC;
    localparam logic [7:0]  CMD_ALU_NOOPER = 8'hDD;
    localparam int unsigned FUN_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GET_FUN,
        ST_EXEC,
        ST_WAIT_RES,
        ST_SEND_LO,
        ST_SEND_HI
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_timer.sv
// Loadable down-counter; expired_c is high while the count sits at zero.
module ctrl_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired_c
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command parser driving the ALU operands/enable and returning
// the result LSB-first over a valid/ready transmit handshake.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OPER_WIDTH    = 8,
    parameter int unsigned OUT_WIDTH     = 16,
    parameter int unsigned FRAME_TIMEOUT = 255,
    parameter int unsigned RESP_TIMEOUT  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output logic [FUN_W-1:0]      ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  CMD_ERR
);

    localparam int unsigned FRAME_W = $clog2(FRAME_TIMEOUT);
    localparam int unsigned RESP_W  = $clog2(RESP_TIMEOUT);

    ctrl_state_e           state_q, next_state_c;
    logic                  oper_q;
    logic [OPER_WIDTH-1:0] sh_a_q, sh_b_q;
    logic [7:0]            res_hi_q;

    logic err_c, set_oper_c, sh_a_we_c, sh_b_we_c, fun_we_c, cap_c, hi_load_c;
    logic frame_load_c, frame_dec_c, frame_exp_c;
    logic resp_load_c, resp_dec_c, resp_exp_c;

    ctrl_timer #(.WIDTH(FRAME_W)) u_frame_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (frame_load_c),
        .load_val  (FRAME_W'(FRAME_TIMEOUT - 1)),
        .dec       (frame_dec_c),
        .expired_c (frame_exp_c)
    );

    ctrl_timer #(.WIDTH(RESP_W)) u_resp_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (resp_load_c),
        .load_val  (RESP_W'(RESP_TIMEOUT - 1)),
        .dec       (resp_dec_c),
        .expired_c (resp_exp_c)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            oper_q   <= 1'b0;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            res_hi_q <= '0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_FUN  <= '0;
            ALU_EN   <= 1'b0;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            CMD_ERR  <= 1'b0;
        end else begin
            state_q  <= next_state_c;
            CMD_ERR  <= err_c;
            ALU_EN   <= (next_state_c == ST_EXEC);
            BUSY     <= (next_state_c != ST_IDLE);
            TX_VALID <= (next_state_c == ST_SEND_LO) || (next_state_c == ST_SEND_HI);
            if (set_oper_c) oper_q <= (RX_DATA == CMD_ALU_OPER);
            if (sh_a_we_c)  sh_a_q <= OPER_WIDTH'(RX_DATA);
            if (sh_b_we_c)  sh_b_q <= OPER_WIDTH'(RX_DATA);
            // Operands only commit once the whole frame has been accepted.
            if (fun_we_c) begin
                ALU_FUN <= RX_DATA[FUN_W-1:0];
                if (oper_q) begin
                    ALU_A <= sh_a_q;
                    ALU_B <= sh_b_q;
                end
            end
            if (cap_c) begin
                TX_DATA  <= ALU_OUT[7:0];
                res_hi_q <= 8'(ALU_OUT >> 8);
            end else if (hi_load_c) begin
                TX_DATA <= res_hi_q;
            end
        end
    end

    always_comb begin
        next_state_c = state_q;
        err_c        = 1'b0;
        set_oper_c   = 1'b0;
        sh_a_we_c    = 1'b0;
        sh_b_we_c    = 1'b0;
        fun_we_c     = 1'b0;
        cap_c        = 1'b0;
        hi_load_c    = 1'b0;
        frame_load_c = 1'b0;
        frame_dec_c  = 1'b0;
        resp_load_c  = 1'b0;
        resp_dec_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == CMD_ALU_OPER) begin
                        next_state_c = ST_GET_A;
                        set_oper_c   = 1'b1;
                        frame_load_c = 1'b1;
                    end else if (RX_DATA == CMD_ALU_NOOPER) begin
                        next_state_c = ST_GET_FUN;
                        set_oper_c   = 1'b1;
                        frame_load_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            ST_GET_A, ST_GET_B, ST_GET_FUN: begin
                if (RX_VALID) begin
                    frame_load_c = 1'b1;
                    if (state_q == ST_GET_A) begin
                        sh_a_we_c    = 1'b1;
                        next_state_c = ST_GET_B;
                    end else if (state_q == ST_GET_B) begin
                        sh_b_we_c    = 1'b1;
                        next_state_c = ST_GET_FUN;
                    end else if (RX_DATA[7:FUN_W] != '0) begin
                        err_c        = 1'b1;
                        next_state_c = ST_IDLE;
                    end else begin
                        fun_we_c     = 1'b1;
                        next_state_c = ST_EXEC;
                    end
                end else if (frame_exp_c) begin
                    err_c        = 1'b1;
                    next_state_c = ST_IDLE;
                end else begin
                    frame_dec_c = 1'b1;
                end
            end
            ST_EXEC: begin
                resp_load_c  = 1'b1;
                next_state_c = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    cap_c        = 1'b1;
                    next_state_c = ST_SEND_LO;
                end else if (resp_exp_c) begin
                    err_c        = 1'b1;
                    next_state_c = ST_IDLE;
                end else begin
                    resp_dec_c = 1'b1;
                end
            end
            ST_SEND_LO: begin
                if (TX_READY) begin
                    if (OUT_WIDTH == 16) begin
                        hi_load_c    = 1'b1;
                        next_state_c = ST_SEND_HI;
                    end else begin
                        next_state_c = ST_IDLE;
                    end
                end
            end
            ST_SEND_HI: begin
                if (TX_READY) next_state_c = ST_IDLE;
            end
            default: next_state_c = ST_IDLE;
        endcase

        // Bytes arriving while a command is in flight are dropped and flagged.
        if (RX_VALID && (state_q inside {ST_EXEC, ST_WAIT_RES, ST_SEND_LO, ST_SEND_HI})) begin
            err_c = 1'b1;
        end
    end

endmodule
